// File: rtl/memaccess_pkg.sv
// ============================================================================
// memaccess_pkg : shared encodings, state enum and widths for memaccess
// Rev 1.0
// ============================================================================
`default_nettype none

package memaccess_pkg;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int TAG_W     = 6;
    localparam int MEM_IDX_W = 16;

    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_LOAD  = 2'b01,
        OP_STORE = 2'b10,
        OP_SWAP  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_WRITE = 2'b10,
        ST_RESP  = 2'b11
    } state_e;

    // Only the low MEM_IDX_W address bits reach the data memory.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1:MEM_IDX_W] == '0;
    endfunction

    function automatic state_e first_state(input op_e op, input logic [ADDR_W-1:0] addr);
        if (op == OP_NOP)
            return ST_IDLE;
        else if (!addr_ok(addr))
            return ST_RESP;
        else if (op == OP_STORE)
            return ST_WRITE;
        else
            return ST_READ;
    endfunction

endpackage

`default_nettype wire

// File: rtl/memaccess.sv
// ============================================================================
// memaccess : single-outstanding LOAD/STORE/SWAP engine between a request
//             port, a negedge-sampled data memory and a writeback port.
// Rev 1.0
// ============================================================================
`default_nettype none

module memaccess
    import memaccess_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [TAG_W-1:0]  req_rd,
    output logic              mem_rd,
    output logic              mem_wrt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_datain,
    input  logic [DATA_W-1:0] mem_dataout,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [DATA_W-1:0] wb_data,
    output logic [TAG_W-1:0]  wb_rd,
    output logic              wb_we,
    output logic              wb_err
);

    state_e            r_state;
    state_e            w_next;
    op_e               r_op;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic [TAG_W-1:0]  r_rd;
    logic              r_err;
    logic              w_accept;

    // rst gates readiness so nothing is advertised while reset is held.
    assign req_ready = ~rst & ((r_state == ST_IDLE) | ((r_state == ST_RESP) & wb_ready));
    assign w_accept  = req_valid & req_ready;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:  w_next = ST_IDLE;
            ST_READ:  w_next = (r_op == OP_SWAP) ? ST_WRITE : ST_RESP;
            ST_WRITE: w_next = ST_RESP;
            ST_RESP:  w_next = wb_ready ? ST_IDLE : ST_RESP;
        endcase
        if (w_accept)
            w_next = first_state(op_e'(req_op), req_addr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_op    <= OP_NOP;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_rd    <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_op    <= op_e'(req_op);
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_rd    <= req_rd;
                r_err   <= (op_e'(req_op) != OP_NOP) & ~addr_ok(req_addr);
            end
            if (r_state == ST_READ)
                r_rdata <= mem_dataout;
        end
    end

    // Strobes decode straight from state so async reset drops them at once.
    assign mem_rd     = (r_state == ST_READ);
    assign mem_wrt    = (r_state == ST_WRITE);
    assign mem_addr   = r_addr;
    assign mem_datain = r_wdata;

    assign wb_valid = (r_state == ST_RESP);
    assign wb_rd    = wb_valid ? r_rd : '0;
    assign wb_err   = wb_valid & r_err;
    assign wb_we    = wb_valid & ~r_err & (r_op != OP_STORE);
    assign wb_data  = wb_we ? r_rdata : '0;

endmodule

`default_nettype wire

// File: tb/tb_memaccess.sv
// ============================================================================
// tb_memaccess : directed vector bench for memaccess with a negedge data memory
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_memaccess;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b00;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [5:0]  req_rd = '0;
    logic        mem_rd, mem_wrt;
    logic [31:0] mem_addr, mem_datain;
    logic [31:0] mem_dataout = '0;
    logic        wb_valid;
    logic        wb_ready = 1'b1;
    logic [31:0] wb_data;
    logic [5:0]  wb_rd;
    logic        wb_we, wb_err;

    int n_tests = 0;
    int n_fail  = 0;

    memaccess dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .mem_rd(mem_rd), .mem_wrt(mem_wrt), .mem_addr(mem_addr),
        .mem_datain(mem_datain), .mem_dataout(mem_dataout),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
        .wb_rd(wb_rd), .wb_we(wb_we), .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    // Data memory: samples strobes on negedge, preloaded on its first edge.
    logic [31:0] mem [0:255];
    logic        loaded = 1'b0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          prot_err = 0;

    always @(negedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
            mem[2] <= 32'd3;
            mem[3] <= 32'hFFFF_FFFC;
            mem[4] <= 32'd5;
            loaded <= 1'b1;
        end else begin
            if (mem_wrt) mem[mem_addr[7:0]] <= mem_datain;
            if (mem_rd)  mem_dataout <= mem[mem_addr[7:0]];
        end
        if (mem_rd) rd_cnt <= rd_cnt + 1;
        if (mem_wrt) wr_cnt <= wr_cnt + 1;
        if ((mem_rd && mem_wrt) || ((mem_rd || mem_wrt) && mem_addr[31:16] != 16'h0))
            prot_err <= prot_err + 1;
    end

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [5:0]  rd;
        logic [31:0] exp_data;
        logic        exp_we;
        logic        exp_err;
        int          exp_lat;
        int          exp_rds;
        int          exp_wrs;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issues one request with wb_ready=1 and checks latency, fields and strobes.
    task automatic run_req(input vec_t v);
        int lat;
        int rd0, wr0;
        int guard;
        @(negedge clk);
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        req_op = v.op; req_addr = v.addr; req_wdata = v.wdata; req_rd = v.rd;
        req_valid = 1'b1;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) check({v.name, "_accept_timeout"}, 32'd0, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!wb_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check({v.name, "_latency"}, lat, v.exp_lat);
        check({v.name, "_data"}, wb_data, v.exp_data);
        check({v.name, "_rd"}, {26'd0, wb_rd}, {26'd0, v.rd});
        check({v.name, "_we"}, {31'd0, wb_we}, {31'd0, v.exp_we});
        check({v.name, "_err"}, {31'd0, wb_err}, {31'd0, v.exp_err});
        check({v.name, "_rd_strobes"}, rd_cnt - rd0, v.exp_rds);
        check({v.name, "_wr_strobes"}, wr_cnt - wr0, v.exp_wrs);
        @(posedge clk); #1;
    endtask

    initial begin
        int   rd0, wr0, seen;
        vec_t v;

        //          name      op     addr          wdata         rd     data          we    err   lat rds wrs
        vecs[0] = '{"load2",  2'b01, 32'h0000_0002, 32'h0,        6'd5,  32'd3,        1'b1, 1'b0, 2, 1, 0};
        vecs[1] = '{"store10",2'b10, 32'h0000_0010, 32'd7,        6'd1,  32'd0,        1'b0, 1'b0, 2, 0, 1};
        vecs[2] = '{"load10", 2'b01, 32'h0000_0010, 32'h0,        6'd2,  32'd7,        1'b1, 1'b0, 2, 1, 0};
        vecs[3] = '{"swap4",  2'b11, 32'h0000_0004, 32'd9,        6'd3,  32'd5,        1'b1, 1'b0, 3, 1, 1};
        vecs[4] = '{"load4",  2'b01, 32'h0000_0004, 32'h0,        6'd4,  32'd9,        1'b1, 1'b0, 2, 1, 0};
        vecs[5] = '{"ldbad",  2'b01, 32'h0001_0000, 32'h0,        6'd6,  32'd0,        1'b0, 1'b1, 1, 0, 0};
        vecs[6] = '{"stbad",  2'b10, 32'hFFFF_0000, 32'd11,       6'd9,  32'd0,        1'b0, 1'b1, 1, 0, 0};
        vecs[7] = '{"swap5",  2'b11, 32'h0000_0005, 32'h1234_5678,6'd63, 32'd0,        1'b1, 1'b0, 3, 1, 1};
        vecs[8] = '{"load5",  2'b01, 32'h0000_0005, 32'h0,        6'd10, 32'h1234_5678,1'b1, 1'b0, 2, 1, 0};

        // Reset state while rst is held with the clock running
        #13;
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check("rst_strobes", {30'd0, mem_rd, mem_wrt}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_datain", mem_datain, 32'd0);
        check("rst_wb", {25'd0, wb_valid, wb_rd}, 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_wb_flags", {30'd0, wb_we, wb_err}, 32'd0);
        @(negedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_ready", {31'd0, req_ready}, 32'd1);

        for (int i = 0; i < 9; i++) run_req(vecs[i]);

        // NOP: accepted, no access and no response
        @(negedge clk);
        rd0 = rd_cnt; wr0 = wr_cnt;
        req_op = 2'b00; req_addr = 32'd2; req_rd = 6'd12; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("nop_ready", {31'd0, req_ready}, 32'd1);
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (wb_valid) seen++;
        end
        check("nop_no_resp", seen, 0);
        check("nop_no_strobe", (rd_cnt - rd0) + (wr_cnt - wr0), 0);

        // Back-pressure on LOAD 3, then a back-to-back LOAD 2 in the handshake cycle
        @(negedge clk);
        wb_ready = 1'b0;
        req_op = 2'b01; req_addr = 32'd3; req_rd = 6'd7; req_valid = 1'b1;
        @(posedge clk); #1;
        req_addr = 32'd2; req_rd = 6'd8;
        @(posedge clk); #1;
        check("bp_valid", {31'd0, wb_valid}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            check("bp_hold_data", wb_data, 32'hFFFF_FFFC);
            check("bp_hold_tag", {26'd0, wb_rd}, 32'd7);
            check("bp_not_ready", {31'd0, req_ready}, 32'd0);
            @(posedge clk); #1;
        end
        check("bp_still_valid", {31'd0, wb_valid}, 32'd1);
        @(negedge clk);
        wb_ready = 1'b1;
        #1;
        check("bp_ready_on_hs", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("b2b_in_read", {30'd0, mem_rd, wb_valid}, 32'd2);
        @(posedge clk); #1;
        check("b2b_valid", {31'd0, wb_valid}, 32'd1);
        check("b2b_data", wb_data, 32'd3);
        check("b2b_tag", {26'd0, wb_rd}, 32'd8);
        @(posedge clk); #1;

        // Reset pulsed during the WRITE phase of a SWAP, before its negedge
        @(negedge clk);
        wr0 = wr_cnt;
        req_op = 2'b11; req_addr = 32'd2; req_wdata = 32'd1; req_rd = 6'd20; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("swp_rst_in_write", {31'd0, mem_wrt}, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("swp_rst_wrt_drop", {30'd0, mem_rd, mem_wrt}, 32'd0);
        check("swp_rst_no_resp", {30'd0, wb_valid, req_ready}, 32'd0);
        @(negedge clk); #2;
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            if (wb_valid) seen++;
        end
        check("swp_rst_no_wb", seen, 0);
        check("swp_rst_no_write", wr_cnt - wr0, 0);
        v = '{"load2_after_rst", 2'b01, 32'h2, 32'h0, 6'd21, 32'd3, 1'b1, 1'b0, 2, 1, 0};
        run_req(v);

        check("mem_protocol", prot_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

`default_nettype wire
